noise_var_est: RTL and testbench
================================

// Module: noise_var_est
// PURPOSE
//  Per-subcarrier noise-variance estimator; sits directly upstream of payload noise calc (PNC).
//  Takes the two identical long-training FFT symbols (N bins each, back to back),
//    buffers symbol 1, and forms sigma2[k] = |Y2[k]-Y1[k]|^2 / 2 for every bin k.
//  Emits N contiguous-valid 12-bit non-negative sigma2 words, bin order 0..N-1.
//    PNC divides 1578 by these words and keeps the central 480 bins.
// PARAMETERS
//  N      512  FFT bins per training symbol (power of 2)
//  DW     16   signed width of input I/Q
//  OW     12   output width; PNC di format, signed, always >= 1
//  SHIFT  4    extra right shift applied after the /2, before saturation
// PORTS
//  clk     in   1    working clock
//  rst     in   1    reset, asynchronous, active high
//  di_re   in   DW   FFT output real part, signed
//  di_im   in   DW   FFT output imag part, signed
//  di_vld  in   1    input valid; high for 2*N consecutive cycles per frame
//  do      out  OW   sigma2 estimate, signed, range 1..2^(OW-1)-1
//  do_vld  out  1    output valid; exactly N consecutive cycles per good frame
// BEHAVIOUR
//  Reset: do=0, do_vld=0, FSM=IDLE, bin counter=0, pipeline valids=0.
//    RAM contents don't care.
//  FSM (bin counter cnt is log2(N) bits):
//    IDLE: di_vld=1 -> write sample to RAM[0], cnt=1, go SYM1.
//    SYM1: di_vld=1 -> write RAM[cnt], cnt++.
//          At cnt=N-1 the write completes symbol 1; cnt wraps to 0, go SYM2.
//    SYM2: di_vld=1 -> read RAM[cnt] (sync read, 1 cycle), launch pipeline, cnt++.
//          At cnt=N-1 cnt wraps to 0, go IDLE.
//          A sample arriving in IDLE on the very next cycle starts a new frame.
//    di_vld=0 in SYM1 or SYM2: abort, go IDLE, cnt=0.
//      Samples already in the pipeline still drain, so do_vld drops early.
//      PNC's counter resets on the gap.
//  Datapath (SYM2 only), registered stages:
//    S1: register Y2 alongside the RAM read of Y1.
//    S2: dr=Y2re-Y1re, di=Y2im-Y1im, DW+1 bits signed.
//    S3: pr=dr*dr, pi=di*di, 2*DW+2 bits unsigned.
//    S4: s=(pr+pi)>>(1+SHIFT); clamp to 1..2^(OW-1)-1 -> do; do_vld=S3 valid.
//  Latency: SYM2 sample k on di -> do/do_vld 4 cycles later.
//    Throughput 1 bin/cycle, no backpressure.
//  Clamp to 1 is mandatory; the downstream divider must never see 0.
//  Clamp to 2047 when OW=12.
//  do holds its last value when do_vld=0.
//    do_vld is driven only by the pipeline valid chain.
//  Simultaneous: last SYM2 sample and first sample of the next frame on back-to-back cycles.
//    No conflict: the new SYM1 writes hit RAM[0..] after the SYM2 reads of those addresses.
//  Reset mid-frame clears FSM and all valids immediately. No partial output after release.
// STRUCTURE
//  Shared global_define.vh: N_FFT=512, IQ_W=16, NOISE_W=12, NOISE_SHIFT=4.
//    Also FSM state localparams IDLE/SYM1/SYM2.
//  Sub-module nve_buf: simple dual-port RAM, N x 2*DW.
//    One write port, one sync-read port, no reset; infers BRAM.
//  FSM, counter, 4-stage arithmetic pipeline and saturation stay in this module.
// TESTING
//  Identical symbols, Y1=Y2=(300,-200) all bins.
//    -> 512 outputs, do=1 each (clamp), do_vld high 512 cycles.
//  Y1=(100,0), Y2=(140,30) all bins.
//    -> s=(1600+900)>>5=78, do=78 for all bins.
//    First do_vld 4 cycles after first SYM2 sample.
//  Y1=(-2000,2000), Y2=(2000,-2000).
//    -> s=(16e6+16e6)>>5=1,000,000, do=2047 (saturate).
//  Bin ramp Y1=(k,0), Y2=(k+8*(k%4),0).
//    -> do pattern 1,2,8,18 repeating; checks address alignment of RAM read.
//  di_vld drops for 1 cycle at SYM2 bin 100.
//    -> do_vld high exactly 100 cycles then low; next full frame gives 512 valid outputs.
//  Two frames back to back with no gap.
//    -> 2 x 512 valid outputs, second frame values from second frame data only.
//  rst pulsed at SYM1 bin 300.
//    -> do=0, do_vld=0; next frame processed normally.

Source files
------------

// File: rtl/noise_var_est_pkg.sv
// Shared constants and FSM state type for the noise-variance estimator.
//   N_FFT       FFT bins per long-training symbol (power of two)
//   IQ_W        signed width of the incoming I/Q samples
//   NOISE_W     output word width (signed, always positive)
//   NOISE_SHIFT extra right shift applied after the /2
package noise_var_est_pkg;

    localparam int N_FFT       = 512;
    localparam int IQ_W        = 16;
    localparam int NOISE_W     = 12;
    localparam int NOISE_SHIFT = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYM1 = 2'd1,
        ST_SYM2 = 2'd2
    } state_t;

endpackage

// File: rtl/noise_var_est_buf.sv
// Symbol-1 buffer: simple dual-port RAM, DEPTH x W, one write port and one
// synchronous read port. No reset so it maps onto block RAM.
//   clk      in   working clock
//   wr_en_i  in   write strobe
//   waddr_i  in   write address
//   wdata_i  in   write data
//   raddr_i  in   read address (data appears one cycle later)
//   rdata_o  out  registered read data
module nve_buf #(
    parameter int DEPTH = 512,
    parameter int W     = 32
) (
    input  logic                     clk,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [W-1:0]             wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [W-1:0]             rdata_o
);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/noise_var_est.sv
// Per-subcarrier noise-variance estimator. Two identical long-training FFT
// symbols arrive back to back; symbol 1 is buffered, and while symbol 2
// streams in each bin produces sigma2 = (|Y2-Y1|^2 / 2) >> SHIFT, clamped to
// 1..2^(OW-1)-1 so the downstream divider never sees zero.
//   clk      in   working clock
//   rst      in   asynchronous active-high reset
//   di_re    in   FFT real part, signed DW
//   di_im    in   FFT imag part, signed DW
//   di_vld   in   input valid, 2*N consecutive cycles per frame
//   do_o     out  sigma2 estimate, holds last value while do_vld is low
//                 (the plain name "do" is a reserved word)
//   do_vld   out  output valid, N consecutive cycles per good frame
//   state_o  out  current FSM state (state_t encoding), for observation
// Handshake: do_vld qualifies do_o for exactly one cycle per bin; there is
// no backpressure, so the consumer must accept every valid cycle.
module noise_var_est
    import noise_var_est_pkg::*;
#(
    parameter int N     = N_FFT,
    parameter int DW    = IQ_W,
    parameter int OW    = NOISE_W,
    parameter int SHIFT = NOISE_SHIFT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] di_re,
    input  logic [DW-1:0] di_im,
    input  logic          di_vld,
    output logic [OW-1:0] do_o,
    output logic          do_vld,
    output logic [1:0]    state_o
);

    localparam int AW = $clog2(N);
    localparam int PW = 2*DW + 2;          // squared-difference width
    localparam int SW = PW + 1;            // sum of two squares
    localparam logic [AW-1:0] LAST = AW'(N - 1);
    localparam logic [OW-1:0] OMAX = {1'b0, {(OW-1){1'b1}}};

    // ---------------- FSM and bin counter ----------------
    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          wr_en, rd_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // cnt is AW bits, so the increment at N-1 wraps to 0 by itself.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (di_vld) begin
                    wr_en   = 1'b1;
                    cnt_d   = AW'(1);
                    state_d = ST_SYM1;
                end
            end
            ST_SYM1: begin
                if (di_vld) begin
                    wr_en = 1'b1;
                    cnt_d = cnt_q + AW'(1);
                    if (cnt_q == LAST) state_d = ST_SYM2;
                end else begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            ST_SYM2: begin
                if (di_vld) begin
                    rd_en = 1'b1;
                    cnt_d = cnt_q + AW'(1);
                    if (cnt_q == LAST) state_d = ST_IDLE;
                end else begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign state_o = state_q;

    // ---------------- symbol-1 buffer ----------------
    // cnt is 0 in IDLE, so one address serves both ports in every state.
    logic [2*DW-1:0] y1_rd;

    nve_buf #(.DEPTH(N), .W(2*DW)) u_buf (
        .clk     (clk),
        .wr_en_i (wr_en),
        .waddr_i (cnt_q),
        .wdata_i ({di_re, di_im}),
        .raddr_i (cnt_q),
        .rdata_o (y1_rd)
    );

    // ---------------- arithmetic pipeline ----------------
    logic [DW-1:0]        y2re_q, y2im_q;
    logic signed [DW:0]   dr_q, di_q, dr_d, di_d;
    logic [PW-1:0]        pr_q, pi_q, pr_d, pi_d;
    logic signed [PW-1:0] dr_ext, di_ext;
    logic [SW-1:0]        sum, shifted;
    logic [OW-1:0]        sat, do_q;
    logic                 v1_q, v2_q, v3_q, do_vld_q;

    always_comb begin
        dr_d = $signed({y2re_q[DW-1], y2re_q}) - $signed({y1_rd[2*DW-1], y1_rd[2*DW-1:DW]});
        di_d = $signed({y2im_q[DW-1], y2im_q}) - $signed({y1_rd[DW-1], y1_rd[DW-1:0]});
        // Sign-extend before squaring so the product is formed at full width.
        dr_ext = PW'(dr_q);
        di_ext = PW'(di_q);
        pr_d   = dr_ext * dr_ext;
        pi_d   = di_ext * di_ext;
        sum     = {1'b0, pr_q} + {1'b0, pi_q};
        shifted = sum >> (1 + SHIFT);
        if (shifted == '0) begin
            sat = OW'(1);
        end else if (shifted > SW'(OMAX)) begin
            sat = OMAX;
        end else begin
            sat = shifted[OW-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y2re_q   <= '0;
            y2im_q   <= '0;
            dr_q     <= '0;
            di_q     <= '0;
            pr_q     <= '0;
            pi_q     <= '0;
            do_q     <= '0;
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            v3_q     <= 1'b0;
            do_vld_q <= 1'b0;
        end else begin
            // S1: Y2 registered alongside the synchronous RAM read of Y1.
            y2re_q   <= di_re;
            y2im_q   <= di_im;
            v1_q     <= rd_en;
            // S2: differences.
            dr_q     <= dr_d;
            di_q     <= di_d;
            v2_q     <= v1_q;
            // S3: squares.
            pr_q     <= pr_d;
            pi_q     <= pi_d;
            v3_q     <= v2_q;
            // S4: scale and clamp; the output word only moves on valid bins.
            if (v3_q) do_q <= sat;
            do_vld_q <= v3_q;
        end
    end

    assign do_o   = do_q;
    assign do_vld = do_vld_q;

endmodule

// File: tb/tb_noise_var_est.sv
module tb_noise_var_est;
    import noise_var_est_pkg::*;

    localparam int N     = 512;
    localparam int DW    = 16;
    localparam int OW    = 12;
    localparam int SHIFT = 4;

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] di_re, di_im;
    logic          di_vld;
    logic [OW-1:0] do_o;
    logic          do_vld;
    logic [1:0]    state_o;

    always #5 clk = ~clk;

    noise_var_est dut (
        .clk     (clk),
        .rst     (rst),
        .di_re   (di_re),
        .di_im   (di_im),
        .di_vld  (di_vld),
        .do_o    (do_o),
        .do_vld  (do_vld),
        .state_o (state_o)
    );

    // ---------------- bookkeeping ----------------
    int            total = 0;
    int            bad   = 0;
    logic [OW-1:0] exp_q[$];
    logic [OW-1:0] exp_v;
    int            vld_count = 0;
    int            cyc_cnt   = 0;
    int            sym2_t0   = 0;
    int            lat_meas  = -1;
    bit            lat_armed = 0;

    int y1re[N], y1im[N], y2re[N], y2im[N];

    typedef struct {
        int y1re;
        int y1im;
        int y2re;
        int y2im;
        int exp_do;
    } vec_t;
    vec_t tbl[8];

    task automatic check(input string name, input longint got, input longint want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d at t=%0t", name, got, want, $time);
        end
    endtask

    // Reference: sigma2 straight from the definition, integer arithmetic.
    function automatic int ref_sigma(int a_re, int a_im, int b_re, int b_im);
        longint dr, di, s;
        dr = longint'(b_re) - longint'(a_re);
        di = longint'(b_im) - longint'(a_im);
        s  = ((dr*dr + di*di) / 2) / (64'sd1 << SHIFT);
        if (s < 1) return 1;
        if (s > (1 << (OW-1)) - 1) return (1 << (OW-1)) - 1;
        return int'(s);
    endfunction

    always @(posedge clk) cyc_cnt++;

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (do_vld === 1'b1) begin
            vld_count++;
            if (lat_armed) begin
                lat_meas  = cyc_cnt - sym2_t0;
                lat_armed = 0;
            end
            if (exp_q.size() == 0) begin
                check("unexpected_vld", 1, 0);
            end else begin
                exp_v = exp_q.pop_front();
                check("do_value", do_o, exp_v);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v, input int re, input int im);
        di_vld = v;
        di_re  = DW'(re);
        di_im  = DW'(im);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 0, 0);
    endtask

    // drop_at < 0: full frame; otherwise di_vld goes low at that SYM2 bin.
    task automatic send_frame(input int drop_at);
        for (int i = 0; i < N; i++) drive(1'b1, y1re[i], y1im[i]);
        for (int i = 0; i < N; i++) begin
            if (i == drop_at) begin
                drive(1'b0, 0, 0);
                return;
            end
            if (i == 0) begin
                sym2_t0   = cyc_cnt;
                lat_armed = 1;
            end
            drive(1'b1, y2re[i], y2im[i]);
        end
    endtask

    task automatic push_model(input int upto);
        for (int i = 0; i < upto; i++)
            exp_q.push_back(OW'(ref_sigma(y1re[i], y1im[i], y2re[i], y2im[i])));
    endtask

    task automatic fill_random(input int span);
        for (int k = 0; k < N; k++) begin
            y1re[k] = int'($urandom_range(0, 56000)) - 28000;
            y1im[k] = int'($urandom_range(0, 56000)) - 28000;
            y2re[k] = y1re[k] + int'($urandom_range(0, 2*span)) - span;
            y2im[k] = y1im[k] + int'($urandom_range(0, 2*span)) - span;
        end
    endtask

    task automatic drain_check(input string name, input int want_vld);
        repeat (8) @(posedge clk);
        #1;
        check({name, "_vld_count"}, vld_count, want_vld);
        check({name, "_queue_empty"}, exp_q.size(), 0);
        vld_count = 0;
        exp_q.delete();
    endtask

    // ---------------- test sequence ----------------
    int pat[4];

    initial begin
        tbl[0] = '{300, -200, 300, -200, 1};        // identical -> clamp to 1
        tbl[1] = '{100, 0, 140, 30, 78};
        tbl[2] = '{-2000, 2000, 2000, -2000, 2047}; // saturate
        tbl[3] = '{10, 10, -90, -50, 425};
        tbl[4] = '{0, 0, 256, 0, 2047};             // s = 2048, one above max
        tbl[5] = '{0, 0, 6, 0, 1};                  // s = 1 exactly
        tbl[6] = '{0, 0, 0, 255, 2032};
        tbl[7] = '{-32768, -32768, 32767, 32767, 2047};
        pat = '{1, 2, 8, 18};

        rst    = 1'b1;
        di_vld = 1'b0;
        di_re  = '0;
        di_im  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_do", do_o, 0);
        check("reset_do_vld", do_vld, 0);
        check("reset_state", state_o, ST_IDLE);
        rst = 1'b0;
        idle(2);

        // Constant-per-frame vectors.
        for (int t = 0; t < 8; t++) begin
            for (int k = 0; k < N; k++) begin
                y1re[k] = tbl[t].y1re;
                y1im[k] = tbl[t].y1im;
                y2re[k] = tbl[t].y2re;
                y2im[k] = tbl[t].y2im;
                exp_q.push_back(OW'(tbl[t].exp_do));
            end
            lat_meas = -1;
            send_frame(-1);
            idle(1);
            drain_check("table", N);
            check("table_latency", lat_meas, 4);
            check("table_do_hold", do_o, tbl[t].exp_do);
            check("table_vld_low", do_vld, 0);
        end

        // Bin ramp: checks RAM read address alignment.
        for (int k = 0; k < N; k++) begin
            y1re[k] = k;
            y1im[k] = 0;
            y2re[k] = k + 8*(k % 4);
            y2im[k] = 0;
            exp_q.push_back(OW'(pat[k % 4]));
        end
        send_frame(-1);
        idle(1);
        drain_check("ramp", N);

        // Random frames at several difference magnitudes.
        for (int r = 0; r < 3; r++) begin
            fill_random(r == 0 ? 10 : (r == 1 ? 150 : 3000));
            push_model(N);
            send_frame(-1);
            idle(1);
            drain_check("random", N);
        end

        // di_vld gap at SYM2 bin 100, then a clean frame.
        fill_random(150);
        push_model(100);
        send_frame(100);
        check("abort_state", state_o, ST_IDLE);
        drain_check("abort", 100);
        fill_random(150);
        push_model(N);
        send_frame(-1);
        idle(1);
        drain_check("after_abort", N);

        // Two frames back to back, no idle cycle between.
        fill_random(150);
        push_model(N);
        send_frame(-1);
        fill_random(150);
        push_model(N);
        send_frame(-1);
        idle(1);
        drain_check("back_to_back", 2*N);

        // Reset during SYM1 bin 300.
        fill_random(150);
        for (int i = 0; i < 300; i++) drive(1'b1, y1re[i], y1im[i]);
        rst    = 1'b1;
        di_vld = 1'b0;
        #1;
        check("rst_sym1_do", do_o, 0);
        check("rst_sym1_do_vld", do_vld, 0);
        check("rst_sym1_state", state_o, ST_IDLE);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);
        fill_random(150);
        push_model(N);
        send_frame(-1);
        idle(1);
        drain_check("after_rst_sym1", N);

        // Reset during SYM2 bin 200: bins 0..195 have been observed by then,
        // bin 196 reaches the output on the same edge and is cleared 1ns later.
        fill_random(150);
        push_model(196);
        for (int i = 0; i < N; i++) drive(1'b1, y1re[i], y1im[i]);
        for (int i = 0; i < 200; i++) drive(1'b1, y2re[i], y2im[i]);
        rst    = 1'b1;
        di_vld = 1'b0;
        #1;
        check("rst_sym2_do_vld", do_vld, 0);
        check("rst_sym2_state", state_o, ST_IDLE);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        drain_check("rst_sym2", 196);
        fill_random(150);
        push_model(N);
        send_frame(-1);
        idle(1);
        drain_check("after_rst_sym2", N);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
